// File: rtl/timer_multi.sv
// timer_multi: 64-bit mtime with prescaler and NumCmp one-shot/periodic compare channels on a 1 kB bus window.
// Optional TIMER_MTIME_SNAPSHOT_EN: MTIME_LO reads latch the upper half so MTIME_HI reads are tear-free.
module timer_multi #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int NumCmp        = 4,
    parameter int PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    timer_req_i,
    input  logic [AddressWidth-1:0] timer_addr_i,
    input  logic                    timer_we_i,
    input  logic [DataWidth/8-1:0]  timer_be_i,
    input  logic [DataWidth-1:0]    timer_wdata_i,
    output logic                    timer_rvalid_o,
    output logic [DataWidth-1:0]    timer_rdata_o,
    output logic                    timer_err_o,
    output logic                    timer_intr_o,
    output logic [NumCmp-1:0]       timer_intr_vec_o
);
    localparam int Bw = DataWidth / 8;

    if (DataWidth != 32) begin : g_bad_dw
        $error("timer_multi: DataWidth must be 32");
    end
    if (NumCmp < 1 || NumCmp > 16 || PrescaleWidth < 1 || PrescaleWidth > 32) begin : g_bad_cfg
        $error("timer_multi: NumCmp or PrescaleWidth out of range");
    end

    logic [9:0]               off;
    logic [3:0]               ch;
    logic                     glob, chan, bad, wr, rd, en_q, tick;
    logic [5:0]               wr_g;
    logic [DataWidth-1:0]     bm, rdat, hi_rd, rdata_q;
    logic [63:0]              mtime_q, inc;
    logic [PrescaleWidth-1:0] presc_q, presc_cnt;
    logic [NumCmp-1:0]        status_q, ien_q, mode_q, hit, sel, cmp_wr, w1c;
    logic [63:0]              cmp_q [NumCmp];
    logic [31:0]              period_q [NumCmp];
    logic                     rvalid_q, err_q, unused_addr;

    assign off         = timer_addr_i[9:0];
    assign ch          = off[7:4];
    assign unused_addr = ^timer_addr_i[AddressWidth-1:10];
    assign glob        = off[9:5] == 5'd0 && off[4:2] < 3'd6;
    assign chan        = off[9:8] == 2'b01 && 32'(ch) < NumCmp;
    assign bad         = off[1:0] != 2'b00 || !(glob || chan);
    assign wr          = timer_req_i && timer_we_i && !bad;
    assign rd          = timer_req_i && !timer_we_i && !bad;
    assign tick        = en_q && presc_cnt == presc_q;
    assign inc         = mtime_q + 64'(tick);
    assign w1c         = wr_g[4] ? NumCmp'(timer_wdata_i & bm) : '0;

    function automatic logic [31:0] merge(input logic [31:0] old);
        return (old & ~bm) | (timer_wdata_i & bm);
    endfunction

    always_comb begin
        bm     = '0;
        wr_g   = '0;
        sel    = '0;
        cmp_wr = '0;
        hit    = '0;
        for (int b = 0; b < Bw; b++) bm[8*b+:8] = {8{timer_be_i[b]}};
        for (int k = 0; k < 6; k++) wr_g[k] = wr && glob && off[4:2] == 3'(k);
        for (int i = 0; i < NumCmp; i++) begin
            sel[i]    = wr && chan && ch == 4'(i);
            cmp_wr[i] = sel[i] && !off[3];
            hit[i]    = mtime_q >= cmp_q[i] && !cmp_wr[i];
        end
    end

`ifdef TIMER_MTIME_SNAPSHOT_EN
    logic [31:0] shadow_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) shadow_q <= '0;
        else if (rd && glob && off[4:2] == 3'd0) shadow_q <= mtime_q[63:32];
    end
    assign hi_rd = shadow_q;
`else
    assign hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        rdat = '0;
        if (glob) begin
            case (off[4:2])
                3'd0:    rdat = mtime_q[31:0];
                3'd1:    rdat = hi_rd;
                3'd2:    rdat = 32'(en_q);
                3'd3:    rdat = 32'(presc_q);
                3'd4:    rdat = 32'(status_q);
                3'd5:    rdat = 32'(ien_q);
                default: rdat = '0;
            endcase
        end
        for (int i = 0; i < NumCmp; i++)
            if (chan && ch == 4'(i))
                rdat = off[3] ? (off[2] ? period_q[i] : 32'(mode_q[i]))
                              : (off[2] ? cmp_q[i][63:32] : cmp_q[i][31:0]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q   <= '0;
            en_q      <= 1'b1;
            presc_q   <= '0;
            presc_cnt <= '0;
            status_q  <= '0;
            ien_q     <= '0;
            mode_q    <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < NumCmp; i++) begin
                cmp_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            // A written half replaces that half only; the other half keeps the incremented value.
            mtime_q[31:0]  <= wr_g[0] ? merge(mtime_q[31:0]) : inc[31:0];
            mtime_q[63:32] <= wr_g[1] ? merge(mtime_q[63:32]) : inc[63:32];
            presc_cnt      <= (wr_g[3] || tick) ? '0 : en_q ? presc_cnt + PrescaleWidth'(1) : presc_cnt;
            if (wr_g[2] && timer_be_i[0]) en_q <= timer_wdata_i[0];
            if (wr_g[3]) presc_q <= PrescaleWidth'(merge(32'(presc_q)));
            if (wr_g[5]) ien_q <= NumCmp'(merge(32'(ien_q)));
            status_q <= (status_q & ~w1c | hit) & ~cmp_wr;
            for (int i = 0; i < NumCmp; i++) begin
                if (cmp_wr[i])
                    cmp_q[i] <= off[2] ? {merge(cmp_q[i][63:32]), cmp_q[i][31:0]}
                                       : {cmp_q[i][63:32], merge(cmp_q[i][31:0])};
                else if (hit[i] && mode_q[i] && period_q[i] != '0)
                    cmp_q[i] <= cmp_q[i] + 64'(period_q[i]);
                if (sel[i] && off[3:2] == 2'd2 && timer_be_i[0]) mode_q[i] <= timer_wdata_i[0];
                if (sel[i] && off[3:2] == 2'd3) period_q[i] <= merge(period_q[i]);
            end
            rvalid_q <= timer_req_i;
            err_q    <= timer_req_i && bad;
            rdata_q  <= rd ? rdat : '0;
        end
    end

    assign timer_rvalid_o   = rvalid_q;
    assign timer_err_o      = err_q;
    assign timer_rdata_o    = rdata_q;
    assign timer_intr_vec_o = status_q & ien_q;
    assign timer_intr_o     = |timer_intr_vec_o;
endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: directed + randomized checks of timer_multi against closed-form mtime/compare predictions.
module tb_timer_multi;
    localparam logic [31:0] A_MLO = 32'h000, A_MHI = 32'h004, A_CTRL = 32'h008;
    localparam logic [31:0] A_PRE = 32'h00C, A_STAT = 32'h010, A_IEN = 32'h014;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        rvalid, err, intr;
    logic [31:0] rdata;
    logic [3:0]  vec;
    logic        r_valid, r_err;
    logic [31:0] r_data;
    int          cyc = 0, cap = 0;
    int          ncmp = 0, nfail = 0;

    timer_multi dut (
        .clk_i(clk), .rst_ni(rst_n), .timer_req_i(req), .timer_addr_i(addr),
        .timer_we_i(we), .timer_be_i(be), .timer_wdata_i(wdata),
        .timer_rvalid_o(rvalid), .timer_rdata_o(rdata), .timer_err_o(err),
        .timer_intr_o(intr), .timer_intr_vec_o(vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] chan(input int i, input int r);
        return 32'h100 + 32'(16 * i + 4 * r);
    endfunction

    // Expected mtime k edges after counting resumed from base with prescale p.
    function automatic logic [63:0] mt(input logic [63:0] b, input int k, input int p);
        return b + 64'(k / (p + 1));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing posedge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk);
        cap = cyc;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        r_valid = rvalid; r_err = err; r_data = rdata;
    endtask

    task automatic wrb(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        xfer(1'b1, a, b, d);
        check("wresp", {30'h0, r_valid, r_err, r_data}, 64'h2_0000_0000);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wrb(a, 4'hF, d);
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(1'b0, a, 4'hF, 32'h0);
        check("rresp", {62'h0, r_valid, r_err}, 64'h2);
    endtask

    task automatic rd_err(input logic w, input logic [31:0] a);
        xfer(w, a, 4'hF, 32'h5);
        check("err_resp", {30'h0, r_valid, r_err, r_data}, 64'h3_0000_0000);
    endtask

    initial begin
        logic [63:0] base, cval, c2;
        logic [31:0] lo, hi, v, d, ex;
        logic [3:0]  bb;
        int          p, e, f, k, t;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = cyc;
        check("rst_intr", 64'({intr, vec}), 64'd0);
        check("rst_resp", 64'({rvalid, err, rdata}), 64'd0);
        repeat (10) @(negedge clk);
        check("idle_rvalid", 64'(rvalid), 64'd0);
        rd(A_MLO);
        check("t1_mtime", 64'(r_data), 64'(cap - t));
        check("t1_intr", 64'(intr), 64'd0);
        @(negedge clk);
        check("t1_rvalid_drop", 64'(rvalid), 64'd0);

        for (int n = 0; n < 4; n++) begin
            p = (n == 0) ? 3 : int'($urandom_range(0, 5));
            base = (n == 0) ? 64'd0 : 64'($urandom_range(0, 32'h7fff_ffff));
            wr(A_CTRL, 32'd0);
            wr(A_PRE, 32'(p));
            wr(A_MLO, base[31:0]);
            wr(A_MHI, 32'd0);
            wr(A_CTRL, 32'd1);
            e = cap;
            k = (n == 0) ? 40 : int'($urandom_range(3, 40));
            repeat (k) @(negedge clk);
            rd(A_MLO);
            check("t2_run", 64'(r_data), mt(base, cap - 1 - e, p));
            wr(A_CTRL, 32'd0);
            f = cap;
            repeat (20) @(negedge clk);
            rd(A_MLO);
            check("t2_hold", 64'(r_data), mt(base, f - e, p));
        end

        p = int'($urandom_range(0, 2));
        base = 64'(100 - int'($urandom_range(5, 20)));
        wr(A_PRE, 32'(p));
        wr(A_MLO, base[31:0]);
        wr(A_MHI, 32'd0);
        wr(chan(0, 2), 32'd0);
        wr(chan(0, 1), 32'd0);
        wr(chan(0, 0), 32'd100);
        wr(A_STAT, 32'hF);
        wr(A_IEN, 32'd1);
        check("t3_pre_intr", 64'({intr, vec}), 64'd0);
        wr(A_CTRL, 32'd1);
        e = cap;
        for (t = 0; t < 600 && !intr; t++) @(negedge clk);
        check("t3_rise", 64'(cyc), 64'(e) + (64'd100 - base) * 64'(p + 1) + 64'd2);
        check("t3_vec", 64'(vec), 64'd1);
        wr(A_STAT, 32'd1);
        check("t3_w1c_hit", 64'(intr), 64'd1);
        rd(A_STAT);
        check("t3_status", 64'(r_data), 64'hF);
        wr(chan(0, 0), 32'd200);
        check("t3_cmp_clear", 64'(intr), 64'd0);
        @(negedge clk);
        check("t3_cmp_stay", 64'(intr), 64'd0);

        wr(A_CTRL, 32'd0);
        wr(A_PRE, 32'd0);
        wr(A_IEN, 32'd2);
        cval = 64'hFFFF_FFF0;
        base = cval - 64'($urandom_range(8, 30));
        wr(A_MLO, base[31:0]);
        wr(A_MHI, 32'd0);
        wr(chan(1, 3), 32'd50);
        wr(chan(1, 0), 32'hFFFF_FFF0);
        wr(chan(1, 1), 32'd0);
        wr(chan(1, 2), 32'd1);
        wr(A_STAT, 32'd2);
        check("t4_pre_vec", 64'(vec), 64'd0);
        wr(A_CTRL, 32'd1);
        e = cap;
        for (int h = 0; h < 3; h++) begin
            c2 = cval + 64'(50 * h);
            for (t = 0; t < 200 && !vec[1]; t++) @(negedge clk);
            check("t4_hit", 64'(cyc), 64'(e) + (c2 - base) + 64'd2);
            wr(A_STAT, 32'd2);
            check("t4_w1c", 64'(vec), 64'd0);
        end
        c2 = cval + 64'd150;
        rd(chan(1, 0));
        check("t4_cmp_lo", 64'(r_data), 64'(c2[31:0]));
        rd(chan(1, 1));
        check("t4_cmp_hi", 64'(r_data), 64'(c2[63:32]));

        wr(A_CTRL, 32'd0);
        lo = 32'($urandom_range(0, 32'h7fff_ffff));
        hi = 32'($urandom);
        wr(A_MLO, lo);
        wr(A_MHI, hi);
        wr(A_CTRL, 32'd1);
        wrb(A_MHI, 4'b0011, {16'($urandom), 16'h1234});
        rd(A_MLO);
        check("t5_lo", 64'(r_data), 64'(lo + 32'd1));
        rd(A_MHI);
        check("t5_hi", 64'(r_data), 64'({hi[31:16], 16'h1234}));

        for (int n = 0; n < 6; n++) begin
            v = 32'($urandom); d = 32'($urandom); bb = 4'($urandom);
            wr(chan(2, 3), v);
            wrb(chan(2, 3), bb, d);
            rd(chan(2, 3));
            ex = v;
            for (int b = 0; b < 4; b++) if (bb[b]) ex[8*b+:8] = d[8*b+:8];
            check("be_merge", 64'(r_data), 64'(ex));
        end

        wr(A_PRE, 32'd7);
        rd_err(1'b0, 32'h140);
        rd_err(1'b0, 32'h003);
        rd_err(1'b0, 32'h018);
        rd_err(1'b0, 32'h200);
        rd_err(1'b1, 32'h00F);
        rd_err(1'b1, 32'h14C);
        rd(32'hFFFF_FC0C);
        check("t6_pre_kept", 64'(r_data), 64'd7);
        rd(chan(3, 3));
        check("t6_ch3_period", 64'(r_data), 64'd0);

        wr(A_CTRL, 32'd0);
        wr(A_PRE, 32'd0);
        hi = 32'($urandom_range(0, 32'hFFFF_FFFE));
        wr(A_MLO, 32'hFFFF_FFFF);
        wr(A_MHI, hi);
        wr(A_CTRL, 32'd1);
        rd(A_MLO);
        check("snap_lo", 64'(r_data), 64'hFFFF_FFFF);
        rd(A_MHI);
`ifdef TIMER_MTIME_SNAPSHOT_EN
        check("snap_hi", 64'(r_data), 64'(hi));
`else
        check("live_hi", 64'(r_data), 64'(hi + 32'd1));
`endif

        req = 1'b1; we = 1'b0; addr = A_CTRL; be = 4'hF;
        @(posedge clk);
        #2;
        check("rst_pend_pre", 64'({rvalid, rdata}), 64'h1_0000_0001);
        rst_n = 1'b0;
        #1;
        check("rst_pend", 64'({rvalid, err, intr, rdata}), 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(A_CTRL);
        check("rst_ctrl", 64'(r_data), 64'd1);
        rd(A_PRE);
        check("rst_pre", 64'(r_data), 64'd0);
        rd(A_IEN);
        check("rst_ien", 64'(r_data), 64'd0);
        check("rst_intr_after", 64'({intr, vec}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
